// File: rtl/instruction_queue.sv
// DEPTH-entry instruction prefetch queue with combinational field decode of the head entry.
// Circular buffer with explicit pointer wrap, so DEPTH need not be a power of two.
module instruction_queue #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [INSTR_W-1:0]           input_IR_Instru,
  input  logic                         input_IR_valid,
  output logic                         Output_IR_ready,
  input  logic                         input_IR_advance,
  input  logic                         input_IR_flush,
  output logic                         Output_IR_valid,
  output logic [INSTR_W-1:0]           Output_IR_Instru,
  output logic [OPC_W-1:0]             Output_IR_Opcode,
  output logic [REG_W-1:0]             Output_IR_RegD,
  output logic [REG_W-1:0]             Output_IR_RegA,
  output logic [REG_W-1:0]             Output_IR_RegB,
  output logic [INSTR_W-1:0]           Output_IR_Imm,
  output logic [$clog2(DEPTH+1)-1:0]   Output_IR_Count,
  output logic                         Output_IR_Drop
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               drop_q, drop_d;
  logic               full, empty;
  logic               push_acc, pop_acc, push_rej;
  logic [INSTR_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [INSTR_W-1:0] sign_ext(input logic [INSTR_W-1:0] w);
    logic [INSTR_W-1:0] r;
    for (int i = 0; i < INSTR_W; i++) begin
      r[i] = (i < IMM_W) ? w[i] : w[IMM_W-1];
    end
    return r;
  endfunction

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  // Flush wins over a concurrent push or advance.
  assign push_acc = input_IR_valid && !full && !input_IR_flush;
  assign pop_acc  = input_IR_advance && !empty && !input_IR_flush;
  assign push_rej = input_IR_valid && full && !input_IR_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    if (input_IR_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      drop_d   = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_acc, pop_acc})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (push_rej) drop_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is not reset; stale contents are hidden behind the valid mask.
  always_ff @(posedge CLK) begin
    if (push_acc && !Reset) mem_q[wr_ptr_q] <= input_IR_Instru;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign Output_IR_ready  = !full;
  assign Output_IR_valid  = !empty;
  assign Output_IR_Count  = cnt_q;
  assign Output_IR_Drop   = drop_q;
  assign Output_IR_Instru = head;
  assign Output_IR_Opcode = head[INSTR_W-1 -: OPC_W];
  assign Output_IR_RegD   = head[INSTR_W-OPC_W-1 -: REG_W];
  assign Output_IR_RegA   = head[INSTR_W-OPC_W-REG_W-1 -: REG_W];
  assign Output_IR_RegB   = head[REG_W-1:0];
  assign Output_IR_Imm    = sign_ext(head);

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: a DEPTH=4 instance driven from a vector table,
// and a DEPTH=3 instance exercised by a hand-written wrap-around sequence.
module tb_instruction_queue;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // DEPTH=4 instance
  logic        rst4, vld4, adv4, fl4;
  logic [15:0] din4;
  logic        rdy4, ov4, drop4;
  logic [15:0] oi4, oimm4;
  logic [3:0]  opc4, rd4, ra4, rb4;
  logic [2:0]  cnt4;

  instruction_queue #(.INSTR_W(16), .DEPTH(4), .OPC_W(4), .REG_W(4), .IMM_W(8)) u4 (
    .CLK(CLK), .Reset(rst4), .input_IR_Instru(din4), .input_IR_valid(vld4),
    .Output_IR_ready(rdy4), .input_IR_advance(adv4), .input_IR_flush(fl4),
    .Output_IR_valid(ov4), .Output_IR_Instru(oi4), .Output_IR_Opcode(opc4),
    .Output_IR_RegD(rd4), .Output_IR_RegA(ra4), .Output_IR_RegB(rb4),
    .Output_IR_Imm(oimm4), .Output_IR_Count(cnt4), .Output_IR_Drop(drop4)
  );

  // DEPTH=3 instance
  logic        rst3, vld3, adv3, fl3;
  logic [15:0] din3;
  logic        rdy3, ov3, drop3;
  logic [15:0] oi3, oimm3;
  logic [3:0]  opc3, rd3, ra3, rb3;
  logic [1:0]  cnt3;

  instruction_queue #(.INSTR_W(16), .DEPTH(3), .OPC_W(4), .REG_W(4), .IMM_W(8)) u3 (
    .CLK(CLK), .Reset(rst3), .input_IR_Instru(din3), .input_IR_valid(vld3),
    .Output_IR_ready(rdy3), .input_IR_advance(adv3), .input_IR_flush(fl3),
    .Output_IR_valid(ov3), .Output_IR_Instru(oi3), .Output_IR_Opcode(opc3),
    .Output_IR_RegD(rd3), .Output_IR_RegA(ra3), .Output_IR_RegB(rb3),
    .Output_IR_Imm(oimm3), .Output_IR_Count(cnt3), .Output_IR_Drop(drop3)
  );

  typedef struct {
    logic        rst, vld, adv, fl;
    logic [15:0] din;
    logic        ev, er;
    logic [2:0]  ec;
    logic        ed;
    logic [15:0] ei, eimm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, vld, adv, fl, input logic [15:0] din,
                     input logic ev, er, input logic [2:0] ec, input logic ed,
                     input logic [15:0] ei, eimm);
    vec_t v;
    v.rst = rst; v.vld = vld; v.adv = adv; v.fl = fl; v.din = din;
    v.ev = ev; v.er = er; v.ec = ec; v.ed = ed; v.ei = ei; v.eimm = eimm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive3(input logic rst, vld, adv, input logic [15:0] din);
    rst3 = rst; vld3 = vld; adv3 = adv; din3 = din; fl3 = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    rst4 = 1'b1; vld4 = 1'b0; adv4 = 1'b0; fl4 = 1'b0; din4 = '0;
    rst3 = 1'b1; vld3 = 1'b0; adv3 = 1'b0; fl3 = 1'b0; din3 = '0;

    //  rst vld adv fl  din       ev er ec ed  instr     imm
    add(1, 0, 0, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(1, 0, 0, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 1, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h1A2B,   1, 1, 1, 0, 16'h1A2B, 16'h002B);
    add(0, 0, 0, 0, 16'h0000,   1, 1, 1, 0, 16'h1A2B, 16'h002B);
    add(0, 0, 0, 0, 16'h0000,   1, 1, 1, 0, 16'h1A2B, 16'h002B);
    add(0, 0, 0, 0, 16'h0000,   1, 1, 1, 0, 16'h1A2B, 16'h002B);
    add(0, 0, 1, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h3C8F,   1, 1, 1, 0, 16'h3C8F, 16'hFF8F);
    add(0, 1, 0, 0, 16'h5001,   1, 1, 2, 0, 16'h3C8F, 16'hFF8F);
    add(0, 1, 0, 0, 16'h7FFF,   1, 1, 3, 0, 16'h3C8F, 16'hFF8F);
    add(0, 1, 0, 0, 16'h9123,   1, 0, 4, 0, 16'h3C8F, 16'hFF8F);
    add(0, 1, 0, 0, 16'hAAAA,   1, 0, 4, 1, 16'h3C8F, 16'hFF8F);
    add(0, 0, 1, 0, 16'h0000,   1, 1, 3, 1, 16'h5001, 16'h0001);
    add(0, 0, 1, 0, 16'h0000,   1, 1, 2, 1, 16'h7FFF, 16'hFFFF);
    add(0, 0, 1, 0, 16'h0000,   1, 1, 1, 1, 16'h9123, 16'h0023);
    add(0, 0, 1, 0, 16'h0000,   0, 1, 0, 1, 16'h0000, 16'h0000);
    add(0, 0, 0, 1, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h1111,   1, 1, 1, 0, 16'h1111, 16'h0011);
    add(0, 1, 0, 0, 16'h2222,   1, 1, 2, 0, 16'h1111, 16'h0011);
    add(0, 1, 0, 0, 16'h3333,   1, 1, 3, 0, 16'h1111, 16'h0011);
    add(0, 1, 0, 0, 16'h4444,   1, 0, 4, 0, 16'h1111, 16'h0011);
    add(0, 1, 1, 0, 16'h5555,   1, 1, 3, 1, 16'h2222, 16'h0022);
    add(0, 0, 1, 0, 16'h0000,   1, 1, 2, 1, 16'h3333, 16'h0033);
    add(0, 1, 1, 0, 16'h6666,   1, 1, 2, 1, 16'h4444, 16'h0044);
    add(0, 0, 1, 0, 16'h0000,   1, 1, 1, 1, 16'h6666, 16'h0066);
    add(0, 0, 1, 0, 16'h0000,   0, 1, 0, 1, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h0101,   1, 1, 1, 1, 16'h0101, 16'h0001);
    add(0, 1, 0, 0, 16'h0202,   1, 1, 2, 1, 16'h0101, 16'h0001);
    add(0, 1, 0, 0, 16'h0303,   1, 1, 3, 1, 16'h0101, 16'h0001);
    add(0, 1, 1, 1, 16'h4444,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h0505,   1, 1, 1, 0, 16'h0505, 16'h0005);
    add(0, 0, 1, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 1, 0, 0, 16'h7777,   1, 1, 1, 0, 16'h7777, 16'h0077);
    add(1, 1, 1, 0, 16'h8888,   0, 1, 0, 0, 16'h0000, 16'h0000);
    add(0, 0, 0, 0, 16'h0000,   0, 1, 0, 0, 16'h0000, 16'h0000);

    for (int i = 0; i < tbl.size(); i++) begin
      rst4 = tbl[i].rst; vld4 = tbl[i].vld; adv4 = tbl[i].adv;
      fl4 = tbl[i].fl; din4 = tbl[i].din;
      tick();
      e = tbl[i].ei;
      chk($sformatf("v%0d valid", i), ov4,   tbl[i].ev);
      chk($sformatf("v%0d ready", i), rdy4,  tbl[i].er);
      chk($sformatf("v%0d count", i), cnt4,  tbl[i].ec);
      chk($sformatf("v%0d drop",  i), drop4, tbl[i].ed);
      chk($sformatf("v%0d instr", i), oi4,   e);
      chk($sformatf("v%0d imm",   i), oimm4, tbl[i].eimm);
      chk($sformatf("v%0d opc",   i), opc4,  e[15:12]);
      chk($sformatf("v%0d regd",  i), rd4,   e[11:8]);
      chk($sformatf("v%0d rega",  i), ra4,   e[7:4]);
      chk($sformatf("v%0d regb",  i), rb4,   e[3:0]);
    end
    rst4 = 1'b0; vld4 = 1'b0; adv4 = 1'b0; fl4 = 1'b0; din4 = '0;

    // Explicit field decode of 0x1A2B
    vld4 = 1'b1; din4 = 16'h1A2B; tick(); vld4 = 1'b0;
    chk("dec opc",  opc4, 4'h1);
    chk("dec regd", rd4,  4'hA);
    chk("dec rega", ra4,  4'h2);
    chk("dec regb", rb4,  4'hB);
    chk("dec imm",  oimm4, 16'h002B);

    // DEPTH=3 wrap-around: hold occupancy at 2 while pushing and popping together
    drive3(1, 0, 0, 16'h0); tick(); tick();
    drive3(0, 1, 0, 16'h0001); tick();
    chk("w3 cnt1", cnt3, 2'd1);
    drive3(0, 1, 0, 16'h0002); tick();
    chk("w3 cnt2", cnt3, 2'd2);
    chk("w3 head1", oi3, 16'h0001);
    for (int k = 3; k <= 10; k++) begin
      drive3(0, 1, 1, 16'(k)); tick();
      chk($sformatf("w3 head k%0d", k), oi3, 16'(k - 1));
      chk($sformatf("w3 cnt k%0d",  k), cnt3, 2'd2);
      chk($sformatf("w3 rdy k%0d",  k), rdy3, 1'b1);
    end
    drive3(0, 0, 1, 16'h0); tick();
    chk("w3 head10", oi3, 16'h000A);
    chk("w3 cnt tail", cnt3, 2'd1);
    drive3(0, 0, 1, 16'h0); tick();
    chk("w3 empty", ov3, 1'b0);

    // Fill DEPTH=3, overflow, then reset mid-stream
    drive3(0, 1, 0, 16'h000B); tick();
    drive3(0, 1, 0, 16'h000C); tick();
    drive3(0, 1, 0, 16'h000D); tick();
    chk("f3 cnt", cnt3, 2'd3);
    chk("f3 rdy", rdy3, 1'b0);
    drive3(0, 1, 0, 16'h000E); tick();
    chk("f3 drop", drop3, 1'b1);
    chk("f3 head", oi3, 16'h000B);
    drive3(1, 1, 1, 16'h000F); tick();
    chk("r3 valid", ov3, 1'b0);
    chk("r3 ready", rdy3, 1'b1);
    chk("r3 count", cnt3, 2'd0);
    chk("r3 drop",  drop3, 1'b0);
    chk("r3 instr", oi3, 16'h0000);
    chk("r3 imm",   oimm3, 16'h0000);
    drive3(0, 0, 0, 16'h0); tick();
    chk("r3 idle count", cnt3, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
